// File: rtl/mul_iter.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU, STEP bits per cycle.
// Accept -> iterate N=32/STEP cycles -> registered one-cycle writeback pulse.
module mul_iter #(
  parameter int STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        opcode_valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] ra_i,
  input  logic [31:0] rb_i,
  output logic        busy_o,
  output logic        writeback_valid_o,
  output logic [31:0] writeback_value_o
);

  localparam int N  = 32 / STEP;
  localparam int SW = 32 + STEP;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [31:0] mcand, mlr, acc_hi, acc_lo;
  logic [5:0]  cnt;
  logic        negate, is_mul;
  logic        accept, done;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [SW-1:0] partial, sum;
  logic [63:0] acc, result;

  assign accept = (state == IDLE) && opcode_valid_i;
  assign done   = (state == RUN) && (cnt == 6'd0);
  assign busy_o = (state == RUN);

  // MUL yields only low bits, so its operands are taken as unsigned.
  always_comb begin
    sign_a = ((op_i == 2'b01) || (op_i == 2'b10)) && ra_i[31];
    sign_b = (op_i == 2'b01) && rb_i[31];
    mag_a  = sign_a ? -ra_i : ra_i;
    mag_b  = sign_b ? -rb_i : rb_i;
  end

  // Upper half is STEP bits wider than 32 so the carry-out is never lost.
  always_comb begin
    partial = '0;
    for (int k = 0; k < STEP; k++) begin
      if (mlr[k]) partial = partial + ({{STEP{1'b0}}, mcand} << k);
    end
    sum = {{STEP{1'b0}}, acc_hi} + partial;
  end

  always_comb begin
    acc    = {acc_hi, acc_lo};
    result = negate ? -acc : acc;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand             <= '0;
      mlr               <= '0;
      acc_hi            <= '0;
      acc_lo            <= '0;
      cnt               <= '0;
      negate            <= 1'b0;
      is_mul            <= 1'b0;
      writeback_valid_o <= 1'b0;
      writeback_value_o <= '0;
    end else begin
      writeback_valid_o <= 1'b0;
      if (accept) begin
        mcand  <= mag_a;
        mlr    <= mag_b;
        acc_hi <= '0;
        acc_lo <= '0;
        cnt    <= 6'(N);
        negate <= sign_a ^ sign_b;
        is_mul <= (op_i == 2'b00);
      end else if (state == RUN) begin
        if (cnt != 6'd0) begin
          acc_hi <= sum[SW-1:STEP];
          acc_lo <= {sum[STEP-1:0], acc_lo[31:STEP]};
          mlr    <= mlr >> STEP;
          cnt    <= cnt - 6'd1;
        end else begin
          writeback_value_o <= is_mul ? result[31:0] : result[63:32];
          writeback_valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Bench for mul_iter: three instances (STEP=1,2,4) share stimulus; results checked
// against directed vectors and a 64-bit arithmetic reference model.
module tb_mul_iter;

  logic        clk;
  logic        rst;
  logic        opv;
  logic [1:0]  op;
  logic [31:0] ra, rb;
  logic [2:0]  busy, wbv;
  logic [31:0] wbd [3];

  int tests = 0;
  int fails = 0;

  int exp_lat  [3] = '{34, 18, 10};
  int exp_busy [3] = '{33, 17, 9};

  mul_iter #(.STEP(1)) dut1 (.clk_i(clk), .rst_i(rst), .opcode_valid_i(opv), .op_i(op),
    .ra_i(ra), .rb_i(rb), .busy_o(busy[0]), .writeback_valid_o(wbv[0]), .writeback_value_o(wbd[0]));
  mul_iter #(.STEP(2)) dut2 (.clk_i(clk), .rst_i(rst), .opcode_valid_i(opv), .op_i(op),
    .ra_i(ra), .rb_i(rb), .busy_o(busy[1]), .writeback_valid_o(wbv[1]), .writeback_value_o(wbd[1]));
  mul_iter #(.STEP(4)) dut4 (.clk_i(clk), .rst_i(rst), .opcode_valid_i(opv), .op_i(op),
    .ra_i(ra), .rb_i(rb), .busy_o(busy[2]), .writeback_valid_o(wbv[2]), .writeback_value_o(wbd[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step_inst=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issues one op from the current cycle (#1 after an edge) and watches 40 cycles.
  // A non-zero inject cycle pulses a second MUL 9*9 while the instances are busy.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int inject);
    int lat [3];
    int pulses [3];
    int bcnt [3];
    logic [31:0] val [3];
    for (int k = 0; k < 3; k++) begin
      lat[k] = 0; pulses[k] = 0; bcnt[k] = 0; val[k] = '0;
    end
    opv = 1'b1; op = o; ra = a; rb = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1 || (inject != 0 && cyc == inject + 1)) begin
        opv = 1'b0; op = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
      end
      if (inject != 0 && cyc == inject) begin
        opv = 1'b1; op = 2'b00; ra = 32'd9; rb = 32'd9;
      end
      for (int k = 0; k < 3; k++) begin
        if (busy[k]) bcnt[k]++;
        if (wbv[k]) begin
          pulses[k]++;
          if (pulses[k] == 1) begin
            lat[k] = cyc;
            val[k] = wbd[k];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk("result", k, val[k], exp);
      chk("latency", k, 32'(lat[k]), 32'(exp_lat[k]));
      chk("pulses", k, 32'(pulses[k]), 32'd1);
      chk("busy_cycles", k, 32'(bcnt[k]), 32'(exp_busy[k]));
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    int c;
    vt[0] = '{2'b00, 32'd7,          32'd6,          32'h0000_002A};
    vt[1] = '{2'b01, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vt[2] = '{2'b00, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000};
    vt[3] = '{2'b01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF};
    vt[4] = '{2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1};
    vt[5] = '{2'b10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vt[6] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vt[7] = '{2'b01, 32'hFFFF_FFFF,  32'd0,          32'h0000_0000};
    vt[8] = '{2'b10, 32'h8000_0000,  32'h8000_0000,  32'hC000_0000};
    vt[9] = '{2'b11, 32'h8000_0000,  32'd2,          32'h0000_0001};

    rst = 1'b1; opv = 1'b0; op = 2'b00; ra = '0; rb = '0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_busy", k, 32'(busy[k]), 32'd0);
      chk("reset_wbv", k, 32'(wbv[k]), 32'd0);
      chk("reset_wbd", k, wbd[k], 32'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].exp, 0);

    // Issue while busy is ignored.
    run_op(2'b00, 32'd3, 32'd4, 32'h0000_000C, 8);

    // Issue in the STEP=1 writeback cycle.
    opv = 1'b1; op = 2'b00; ra = 32'd5; rb = 32'd5;
    c = 0;
    for (int cyc = 1; cyc <= 40 && c == 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) opv = 1'b0;
      if (wbv[0]) c = cyc;
    end
    chk("b2b_first_lat", 0, 32'(c), 32'd34);
    chk("b2b_first_val", 0, wbd[0], 32'd25);
    run_op(2'b00, 32'd6, 32'd7, 32'd42, 0);

    // Reset in the middle of an operation.
    opv = 1'b1; op = 2'b00; ra = 32'd3; rb = 32'd4;
    repeat (15) begin
      @(posedge clk); #1;
      opv = 1'b0;
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_busy", k, 32'(busy[k]), 32'd0);
      chk("midrst_wbv", k, 32'(wbv[k]), 32'd0);
      chk("midrst_wbd", k, wbd[k], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    c = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (wbv != 3'b000 || busy != 3'b000) c++;
    end
    chk("midrst_quiet", 0, 32'(c), 32'd0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);

    for (int i = 0; i < 1000; i++) begin
      logic [1:0]  ro;
      logic [31:0] a, b;
      ro = 2'($urandom_range(0, 3));
      a  = rnd_operand();
      b  = rnd_operand();
      run_op(ro, a, b, ref_mul(ro, a, b), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
